// File: rtl/shift_load_ctrl.sv
// -----------------------------------------------------------------------------
// shift_load_ctrl
//
// Sequencer that feeds a serial-in/parallel-out register. It takes one
// parallel word over a valid/ready handshake, replays it one bit per cycle on
// serial_out with shift_en high, and then pulses done for one cycle. At that
// point the downstream register holds the whole word.
//
// Parameters
//   WIDTH      bits per frame, 2..32
//   MSB_FIRST  1: in_data[WIDTH-1] goes out first; 0: in_data[0] goes out first
//
// Ports
//   clk         rising-edge clock
//   reset       asynchronous, active-high reset
//   in_valid    producer has a word on in_data
//   in_ready    controller can accept a word (only while idle)
//   in_data     parallel word, sampled only on the handshake edge
//   serial_out  bit for the downstream serial_in
//   shift_en    serial_out is valid this cycle; the downstream register shifts
//   busy        a frame is in progress
//   done        one-cycle pulse when the frame is complete
//
// Every output is driven straight from a flop. No input reaches an output
// through combinational logic only.
//
// Optional feature
//   Define SHIFT_LOAD_CTRL_PARITY_EN to send one extra even-parity bit after
//   the data bits. The parity bit is the XOR of the captured word. The
//   downstream register then needs WIDTH+1 bits.
// -----------------------------------------------------------------------------
module shift_load_ctrl #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             serial_out,
  output logic             shift_en,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
`ifdef SHIFT_LOAD_CTRL_PARITY_EN
  localparam logic [1:0] ST_PAR   = 2'd2;
`endif
  localparam logic [1:0] ST_DONE  = 2'd3;

  logic [1:0]       state_q,      state_d;
  logic [CNT_W-1:0] cnt_q,        cnt_d;
  logic [WIDTH-1:0] hold_q,       hold_d;
  logic             in_ready_q,   in_ready_d;
  logic             serial_out_q, serial_out_d;
  logic             shift_en_q,   shift_en_d;
  logic             busy_q,       busy_d;
  logic             done_q,       done_d;

  // The hold register rotates rather than shifts in zeros. The bit that leaves
  // the outgoing end re-enters at the other end. This keeps every bit of the
  // register live. It also keeps the word's XOR unchanged, so the parity bit
  // can be taken from the hold register at the end of the frame.
  logic [WIDTH-1:0] hold_rot;

  // Returns the bit that goes out first from a word in the configured order.
  function automatic logic lead_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  always_comb begin
    if (MSB_FIRST) hold_rot = {hold_q[WIDTH-2:0], hold_q[WIDTH-1]};
    else           hold_rot = {hold_q[0], hold_q[WIDTH-1:1]};
  end

  // Next-state and next-output logic. Each output flop is loaded with the
  // value it must show in the cycle after the coming edge. This is why the
  // first data bit is already prepared on the handshake edge.
  always_comb begin
    // NOTE: every signal gets a default here, before the case statement, so
    // that no path leaves a value unassigned and no latch is inferred.
    state_d      = state_q;
    cnt_d        = cnt_q;
    hold_d       = hold_q;
    in_ready_d   = 1'b0;
    serial_out_d = 1'b0;
    shift_en_d   = 1'b0;
    busy_d       = 1'b0;
    done_d       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        in_ready_d = 1'b1;
        if (in_valid && in_ready_q) begin
          state_d      = ST_SHIFT;
          hold_d       = in_data;
          cnt_d        = '0;
          in_ready_d   = 1'b0;
          busy_d       = 1'b1;
          shift_en_d   = 1'b1;
          serial_out_d = lead_bit(in_data);
        end
      end

      ST_SHIFT: begin
        busy_d = 1'b1;
        if (cnt_q == LAST_CNT) begin
          // The last data bit is on the wire during this cycle.
`ifdef SHIFT_LOAD_CTRL_PARITY_EN
          state_d      = ST_PAR;
          shift_en_d   = 1'b1;
          serial_out_d = ^hold_q;
`else
          state_d      = ST_DONE;
          done_d       = 1'b1;
`endif
        end else begin
          hold_d       = hold_rot;
          cnt_d        = cnt_q + CNT_W'(1);
          shift_en_d   = 1'b1;
          serial_out_d = lead_bit(hold_rot);
        end
      end

`ifdef SHIFT_LOAD_CTRL_PARITY_EN
      ST_PAR: begin
        busy_d  = 1'b1;
        state_d = ST_DONE;
        done_d  = 1'b1;
      end
`endif

      ST_DONE: begin
        // One cycle with in_ready low. The next word is accepted only once the
        // controller is back in IDLE.
        state_d    = ST_IDLE;
        cnt_d      = '0;
        in_ready_d = 1'b1;
      end

      default: begin
        state_d    = ST_IDLE;
        cnt_d      = '0;
        in_ready_d = 1'b1;
      end
    endcase
  end

  // Reset aborts a frame at once and issues no done pulse. The downstream
  // register is not touched.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      hold_q       <= '0;
      in_ready_q   <= 1'b1;
      serial_out_q <= 1'b0;
      shift_en_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments, so every flop
      // samples the pre-edge values no matter how the statements are ordered.
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      hold_q       <= hold_d;
      in_ready_q   <= in_ready_d;
      serial_out_q <= serial_out_d;
      shift_en_q   <= shift_en_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign serial_out = serial_out_q;
  assign shift_en   = shift_en_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_shift_load_ctrl.sv
// -----------------------------------------------------------------------------
// tb_shift_load_ctrl
//
// Directed bench for shift_load_ctrl. It runs two instances side by side:
//   u_msb  MSB_FIRST=1
//   u_lsb  MSB_FIRST=0
// Both instances see the same handshake stimulus.
//
// A negedge monitor does three things:
//   - models a downstream SIPO register on the MSB-first instance;
//   - logs each transmitted bit;
//   - records the clock edge on which each accept and each done is sampled.
// Edges are numbered by cyc.
// -----------------------------------------------------------------------------
module tb_shift_load_ctrl;

  localparam int W = 4;
`ifdef SHIFT_LOAD_CTRL_PARITY_EN
  localparam int NB = W + 1;
`else
  localparam int NB = W;
`endif
  localparam int DONE_LAT = NB + 1;  // edges from accept to done sampled
  localparam int ACC_GAP  = NB + 2;  // edges between back-to-back accepts

  logic         clk      = 1'b0;
  logic         reset    = 1'b1;
  logic         in_valid = 1'b0;
  logic [W-1:0] in_data  = '0;

  logic ready_m, so_m, sh_m, busy_m, done_m;
  logic ready_l, so_l, sh_l, busy_l, done_l;

  shift_load_ctrl #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (ready_m),
    .in_data    (in_data),
    .serial_out (so_m),
    .shift_en   (sh_m),
    .busy       (busy_m),
    .done       (done_m)
  );

  shift_load_ctrl #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (ready_l),
    .in_data    (in_data),
    .serial_out (so_l),
    .shift_en   (sh_l),
    .busy       (busy_l),
    .done       (done_l)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  int            acc_q[$];
  int            done_m_q[$];
  int            done_l_q[$];
  logic          bits_m[$];
  logic          bits_l[$];
  logic [NB-1:0] q_done[$];
  logic [NB-1:0] sipo_q = '0;

  always @(posedge clk) cyc <= cyc + 1;

  // Values seen at a negedge are the ones the next rising edge (cyc+1) samples.
  always @(negedge clk) begin
    if (!reset) begin
      if (in_valid && ready_m) acc_q.push_back(cyc + 1);
      if (sh_m) begin
        bits_m.push_back(so_m);
        sipo_q = {sipo_q[NB-2:0], so_m};
      end
      if (sh_l) bits_l.push_back(so_l);
      if (done_m) begin
        done_m_q.push_back(cyc + 1);
        q_done.push_back(sipo_q);
      end
      if (done_l) done_l_q.push_back(cyc + 1);
    end
  end

  // Expected bit stream, listed first-sent bit in the MSB position.
  function automatic logic [NB-1:0] exp_msb(input logic [W-1:0] w);
`ifdef SHIFT_LOAD_CTRL_PARITY_EN
    return {w, ^w};
`else
    return w;
`endif
  endfunction

  function automatic logic [NB-1:0] exp_lsb(input logic [W-1:0] w);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) r[i] = w[W-1-i];
`ifdef SHIFT_LOAD_CTRL_PARITY_EN
    return {r, ^w};
`else
    return r;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_rec();
    acc_q.delete();
    done_m_q.delete();
    done_l_q.delete();
    bits_m.delete();
    bits_l.delete();
    q_done.delete();
  endtask

  task automatic wait_acc(input int target);
    for (int i = 0; i < 40 && acc_q.size() < target; i++) step();
    check("accept_count", acc_q.size(), target);
  endtask

  task automatic wait_done(input int target);
    for (int i = 0; i < 40 && done_m_q.size() < target; i++) step();
    check("done_count", done_m_q.size(), target);
    step();
    step();
  endtask

  task automatic send(input logic [W-1:0] w);
    int target;
    target   = acc_q.size() + 1;
    in_data  = w;
    in_valid = 1'b1;
    wait_acc(target);
    in_valid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready_m"}, 32'(ready_m), 1);
    check({tag, "_so_m"},    32'(so_m),    0);
    check({tag, "_sh_m"},    32'(sh_m),    0);
    check({tag, "_busy_m"},  32'(busy_m),  0);
    check({tag, "_done_m"},  32'(done_m),  0);
    check({tag, "_ready_l"}, 32'(ready_l), 1);
    check({tag, "_sh_l"},    32'(sh_l),    0);
    check({tag, "_busy_l"},  32'(busy_l),  0);
  endtask

  // Checks the most recent frame: the bit streams from both instances, the
  // done latency, and the modelled SIPO contents when done is sampled.
  task automatic check_frame(input string tag, input logic [W-1:0] w);
    logic [NB-1:0] em;
    logic [NB-1:0] el;
    em = exp_msb(w);
    el = exp_lsb(w);
    check({tag, "_nbits_m"}, bits_m.size(), NB);
    check({tag, "_nbits_l"}, bits_l.size(), NB);
    for (int i = 0; i < NB; i++) begin
      check($sformatf("%s_bit_m%0d", tag, i),
            32'((i < bits_m.size()) ? bits_m[i] : 1'bx), 32'(em[NB-1-i]));
      check($sformatf("%s_bit_l%0d", tag, i),
            32'((i < bits_l.size()) ? bits_l[i] : 1'bx), 32'(el[NB-1-i]));
    end
    if (done_m_q.size() > 0 && acc_q.size() > 0) begin
      check({tag, "_done_lat_m"}, done_m_q[$] - acc_q[$], DONE_LAT);
      check({tag, "_sipo_q"}, 32'(q_done[$]), 32'(em));
    end
    if (done_l_q.size() > 0 && acc_q.size() > 0)
      check({tag, "_done_lat_l"}, done_l_q[$] - acc_q[$], DONE_LAT);
  endtask

  initial begin
    // Reset: in_valid is held high during reset and must not be accepted.
    reset    = 1'b1;
    in_valid = 1'b1;
    in_data  = 4'b1111;
    #11;
    check_reset_outputs("reset");
    in_valid = 1'b0;
    #1 reset = 1'b0;
    repeat (3) step();
    check("idle_no_shift", bits_m.size(), 0);
    check("idle_no_accept", acc_q.size(), 0);
    check("idle_ready", 32'(ready_m), 1);

    // Basic frame 4'b1011 on both instances.
    clear_rec();
    send(4'b1011);
    check("basic_busy", 32'(busy_m), 1);
    check("basic_ready_low", 32'(ready_m), 0);
    wait_done(1);
    check_frame("basic", 4'b1011);
    check("basic_idle_ready", 32'(ready_m), 1);
    check("basic_idle_busy", 32'(busy_m), 0);

    // Back-to-back frames: in_valid stays high, and the word changes after
    // the first accept.
    clear_rec();
    in_data  = 4'b0110;
    in_valid = 1'b1;
    wait_acc(1);
    in_data  = 4'b1001;
    wait_acc(2);
    in_valid = 1'b0;
    wait_done(2);
    if (acc_q.size() == 2) check("b2b_accept_gap", acc_q[1] - acc_q[0], ACC_GAP);
    check("b2b_done_pulses", done_m_q.size(), 2);
    if (q_done.size() == 2) begin
      check("b2b_q0", 32'(q_done[0]), 32'(exp_msb(4'b0110)));
      check("b2b_q1", 32'(q_done[1]), 32'(exp_msb(4'b1001)));
    end
    if (done_m_q.size() == 2)
      check("b2b_done_lat2", done_m_q[1] - acc_q[1], DONE_LAT);

    // A request while busy is ignored, and the frame in flight is unchanged.
    clear_rec();
    send(4'b1011);
    step();
    step();
    in_valid = 1'b1;
    in_data  = 4'b1111;
    step();
    check("busy_ready_low", 32'(ready_m), 0);
    check("busy_busy", 32'(busy_m), 1);
    check("busy_shifting", 32'(sh_m), 1);
    in_valid = 1'b0;
    in_data  = 4'b0000;
    wait_done(1);
    check_frame("busy", 4'b1011);
    repeat (3) step();
    check("busy_single_accept", acc_q.size(), 1);

    // Reset is asserted in the second shift_en cycle, which aborts the frame.
    clear_rec();
    send(4'b1011);
    step();
    check("abort_pre_sh", 32'(sh_m), 1);
    #2 reset = 1'b1;
    #1;
    check_reset_outputs("abort");
    step();
    reset = 1'b0;
    repeat (8) step();
    check("abort_no_done_m", done_m_q.size(), 0);
    check("abort_no_done_l", done_l_q.size(), 0);
    check("abort_idle_sh", 32'(sh_m), 0);

    // A fresh frame completes normally after the abort.
    clear_rec();
    send(4'b0101);
    wait_done(1);
    check_frame("post_abort", 4'b0101);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
